// File: rtl/timeout_static_priority_arbiter.sv
// rtl/timeout_static_priority_arbiter.sv - static-priority arbiter with per-channel starvation timeout
module timeout_static_priority_arbiter #(
  parameter int    SIZE    = 4,
  parameter int    TIMEOUT = 8,
  parameter string VARIANT = "fast"
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [SIZE-1:0] requests,
  output logic [SIZE-1:0] grant
);

  localparam int            CW     = $clog2(TIMEOUT);
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0]   countdown [SIZE];
  logic [SIZE-1:0] timed_out;
  logic [SIZE-1:0] timed_pick;
  logic [SIZE-1:0] request_pick;

  always_comb begin
    timed_out = '0;
    for (int i = 0; i < SIZE; i++) begin
      timed_out[i] = requests[i] && (countdown[i] == '0);
    end
  end

  // Two lowest-index-wins encoders: one over starved channels, one over all requests.
  generate
    if (VARIANT == "fast") begin : g_fast
      assign timed_pick   = timed_out & (~timed_out + SIZE'(1));
      assign request_pick = requests  & (~requests  + SIZE'(1));
    end else if (VARIANT == "small") begin : g_small
      logic [SIZE-1:0] t_seen;
      logic [SIZE-1:0] r_seen;
      assign t_seen[0] = 1'b0;
      assign r_seen[0] = 1'b0;
      for (genvar i = 0; i < SIZE; i++) begin : g_bit
        assign timed_pick[i]   = timed_out[i] & ~t_seen[i];
        assign request_pick[i] = requests[i]  & ~r_seen[i];
        if (i < SIZE - 1) begin : g_next
          assign t_seen[i+1] = t_seen[i] | timed_out[i];
          assign r_seen[i+1] = r_seen[i] | requests[i];
        end
      end
    end else begin : g_bad
      $error("timeout_static_priority_arbiter: VARIANT must be \"fast\" or \"small\"");
    end
  endgenerate

  assign grant = (|timed_out) ? timed_pick : request_pick;

  // Idle channels hold their countdown so waiting only accrues while requesting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) begin
        countdown[i] <= RELOAD;
      end
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (grant[i]) begin
          countdown[i] <= RELOAD;
        end else if (requests[i] && (countdown[i] != '0)) begin
          countdown[i] <= countdown[i] - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_timeout_static_priority_arbiter.sv
// tb/tb_timeout_static_priority_arbiter.sv - directed and random checks of the timeout arbiter
module tb_timeout_static_priority_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] requests = 4'b0000;
  logic [3:0] grant_fast;
  logic [3:0] grant_small;
  int         passed = 0;
  int         total = 0;

  always #5 clock = ~clock;

  timeout_static_priority_arbiter #(.SIZE(4), .TIMEOUT(8), .VARIANT("fast")) dut_fast (
    .clock(clock), .reset(reset), .requests(requests), .grant(grant_fast)
  );

  timeout_static_priority_arbiter #(.SIZE(4), .TIMEOUT(8), .VARIANT("small")) dut_small (
    .clock(clock), .reset(reset), .requests(requests), .grant(grant_small)
  );

  task automatic check(input logic [3:0] expected, input string tag);
    total++;
    assert (grant_fast === expected) passed++;
    else $error("FAIL %s fast: observed %b expected %b", tag, grant_fast, expected);
    total++;
    assert (grant_small === expected) passed++;
    else $error("FAIL %s small: observed %b expected %b", tag, grant_small, expected);
  endtask

  task automatic prop(input logic ok, input string tag, input logic [3:0] obs, input logic [3:0] req);
    total++;
    assert (ok === 1'b1) passed++;
    else $error("FAIL %s: observed grant %b with requests %b, required property true", tag, obs, req);
  endtask

  task automatic apply(input logic [3:0] r);
    @(negedge clock);
    requests = r;
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    requests = 4'b0000;
    #1;
    check(4'b0000, {tag, " reset_idle"});
    requests = 4'b1110;
    #1;
    check(4'b0010, {tag, " reset_static"});
    requests = 4'b0000;
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [3:0] lowest_bit [16] = '{4'b0000, 4'b0001, 4'b0010, 4'b0001,
                                  4'b0100, 4'b0001, 4'b0010, 4'b0001,
                                  4'b1000, 4'b0001, 4'b0010, 4'b0001,
                                  4'b0100, 4'b0001, 4'b0010, 4'b0001};
  int req_cnt [4];
  int gnt_cnt [4];

  initial begin
    // Exhaustive single-cycle patterns from reset
    for (int v = 0; v < 16; v++) begin
      do_reset("exh");
      apply(4'(v));
      check(lowest_bit[v], $sformatf("exhaustive req=%b", 4'(v)));
    end

    // Starvation of channel n against channel 0
    for (int n = 1; n < 4; n++) begin
      do_reset("starve");
      for (int c = 0; c < 100; c++) begin
        apply(4'b0001 | 4'(1 << n));
        check((c % 8 == 7) ? 4'(1 << n) : 4'b0001, $sformatf("starve n%0d c%0d", n, c));
      end
    end

    // All channels requesting
    do_reset("all");
    for (int c = 0; c < 42; c++) begin
      logic [3:0] exp;
      apply(4'b1111);
      if (c < 7) exp = 4'b0001;
      else begin
        case ((c - 7) % 8)
          0:       exp = 4'b0010;
          1:       exp = 4'b0100;
          2:       exp = 4'b1000;
          default: exp = 4'b0001;
        endcase
      end
      check(exp, $sformatf("all_timeout c%0d", c));
    end

    // Pulsed request: countdown holds while channel n is idle
    for (int n = 1; n < 4; n++) begin
      do_reset("pulse");
      for (int c = 0; c < 64; c++) begin
        apply((c % 2 == 1) ? (4'b0001 | 4'(1 << n)) : 4'b0001);
        check((c % 16 == 15) ? 4'(1 << n) : 4'b0001, $sformatf("pulse n%0d c%0d", n, c));
      end
    end

    // Mid-run reset must reload the countdowns
    do_reset("reload");
    for (int c = 0; c < 5; c++) apply(4'b0011);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check(4'b0001, "reload during_reset");
    requests = 4'b0000;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 7; c++) begin
      apply(4'b0011);
      check(4'b0001, $sformatf("reload c%0d", c));
    end
    apply(4'b0011);
    check(4'b0010, "reload timeout");

    // Random traffic with an asynchronous reset in the middle
    do_reset("rand");
    for (int i = 0; i < 4; i++) begin
      req_cnt[i] = 0;
      gnt_cnt[i] = 0;
    end
    for (int c = 0; c < 1000; c++) begin
      apply(4'($urandom_range(0, 15)));
      if (c == 500) begin
        reset = 1'b1;
        #1;
      end
      if (c == 503) begin
        reset = 1'b0;
        #1;
      end
      prop($onehot0(grant_fast), "rand onehot0", grant_fast, requests);
      prop((grant_fast & ~requests) == 4'b0000, "rand grant_implies_request", grant_fast, requests);
      prop((requests == 4'b0000) || (grant_fast != 4'b0000), "rand request_gets_grant", grant_fast, requests);
      prop(grant_small === grant_fast, "rand variants_agree", grant_small, requests);
      for (int i = 0; i < 4; i++) begin
        if (requests[i]) req_cnt[i]++;
        if (grant_fast[i]) gnt_cnt[i]++;
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (req_cnt[i] > 0) begin
        prop(gnt_cnt[i] > 0, $sformatf("rand fairness ch%0d", i), 4'(gnt_cnt[i]), 4'(i));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
